// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM target model.
//   state_t        : responder FSM encoding (INIT / IDLE / READ)
//   strobe_t       : decoded bus strobes (wr / rd / cf)
//   STROBE_W       : width of the raw {ce,we,oe} strobe vector
//   DEF_INIT_VALUE : default fill word used during post-reset initialisation
//   decode_strobes : turns raw ce/we/oe into mutually exclusive wr/rd/cf
package sram_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_READ = 2'd2
  } state_t;

  localparam int STROBE_W = 3;
  localparam logic [15:0] DEF_INIT_VALUE = 16'h0000;

  typedef struct packed {
    logic wr;
    logic rd;
    logic cf;
  } strobe_t;

  function automatic strobe_t decode_strobes(input logic ce, input logic we, input logic oe);
    logic [STROBE_W-1:0] raw;
    strobe_t s;
    raw  = {ce, we, oe};
    s.wr = (raw == 3'b110);
    s.rd = (raw == 3'b101);
    s.cf = (raw == 3'b111);
    return s;
  endfunction

endpackage

// File: rtl/sram_sat_counter.sv
// Saturating up-counter used for the access statistics.
//   sram_clk, rst_n : clock, async active-low reset
//   inc             : count one event this cycle
//   clr             : synchronous clear, wins over inc
//   count           : current value, sticks at all-ones
module sram_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 sram_clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge sram_clk or negedge rst_n) begin
    if (!rst_n)                  count <= '0;
    else if (clr)                count <= '0;
    else if (inc && count != '1) count <= count + CNT_WIDTH'(1);
  end

endmodule

// File: rtl/sram_responder.sv
// Synchronous SRAM target (device end of the ce/we/oe bus).
//   sram_clk, rst_n  : clock, async active-low reset
//   sram_addr_i      : word address
//   sram_data_io     : shared data bus, driven only during a READ-state read
//   sram_ce_i/we_i/oe_i : bus strobes, active-high
//   clear_stats_i    : clears counters and sticky error flags
//   ready_o          : array initialisation finished
//   err_conflict_o   : sticky, ce&we&oe seen while ready
//   err_busy_o       : sticky, ce seen during initialisation
//   wr_count_o/rd_count_o : saturating write-cycle / read-transaction counts
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(DEF_INIT_VALUE),
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  sram_clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] sram_addr_i,
  inout  wire  [DATA_WIDTH-1:0] sram_data_io,
  input  logic                  sram_ce_i,
  input  logic                  sram_we_i,
  input  logic                  sram_oe_i,
  input  logic                  clear_stats_i,
  output logic                  ready_o,
  output logic                  err_conflict_o,
  output logic                  err_busy_o,
  output logic [CNT_WIDTH-1:0]  wr_count_o,
  output logic [CNT_WIDTH-1:0]  rd_count_o
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  state_t                  state, state_nxt;
  strobe_t                 stb;
  logic [ADDR_WIDTH-1:0]   init_addr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_q;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    active;
  logic                    drive;

  assign stb    = decode_strobes(sram_ce_i, sram_we_i, sram_oe_i);
  assign active = (state != ST_INIT);

  // Next state and the single array write port. INIT owns the write port
  // and ignores the bus entirely.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_waddr = sram_addr_i;
    mem_wdata = sram_data_io;
    unique case (state)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = init_addr;
        mem_wdata = INIT_VALUE;
        if (init_addr == '1) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        mem_we = stb.wr;
        if (stb.rd) state_nxt = ST_READ;
      end
      ST_READ: begin
        mem_we = stb.wr;
        if (!stb.rd) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge sram_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_addr <= '0;
      ready_o   <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_o <= (state_nxt != ST_INIT);
      if (state == ST_INIT) init_addr <= init_addr + ADDR_WIDTH'(1);
    end
  end

  // Array contents are deliberately not reset; INIT overwrites every word.
  always_ff @(posedge sram_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Read register reloads on every rd cycle, giving the one-cycle pipeline.
  always_ff @(posedge sram_clk or negedge rst_n) begin
    if (!rst_n)               rd_q <= '0;
    else if (active && stb.rd) rd_q <= mem[sram_addr_i];
  end

  // Combinational release: bus floats the same cycle rd drops or reset hits.
  assign drive        = (state == ST_READ) && stb.rd;
  assign sram_data_io = drive ? rd_q : 'z;

  always_ff @(posedge sram_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_conflict_o <= 1'b0;
      err_busy_o     <= 1'b0;
    end else if (clear_stats_i) begin
      err_conflict_o <= 1'b0;
      err_busy_o     <= 1'b0;
    end else begin
      if (active && stb.cf)    err_conflict_o <= 1'b1;
      if (!active && sram_ce_i) err_busy_o    <= 1'b1;
    end
  end

  sram_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
    .sram_clk (sram_clk),
    .rst_n    (rst_n),
    .inc      (active && stb.wr),
    .clr      (clear_stats_i),
    .count    (wr_count_o)
  );

  // One count per transaction: only the IDLE->READ entry.
  sram_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rd_cnt (
    .sram_clk (sram_clk),
    .rst_n    (rst_n),
    .inc      ((state == ST_IDLE) && stb.rd),
    .clr      (clear_stats_i),
    .count    (rd_count_o)
  );

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: reset/INIT behaviour, directed
// read/write sequences, a vector table, and randomized traffic compared
// against a behavioural memory/statistics model. A second, small instance
// (ADDR_WIDTH=4, CNT_WIDTH=4) exercises counter saturation.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addr;
  logic        ce, we, oe, clr;
  logic [15:0] drv;
  logic        drv_en;
  wire  [15:0] bus;
  logic        ready, ecf, ebusy;
  logic [15:0] wrc, rdc;

  logic [3:0]  s_addr;
  logic        s_ce, s_we, s_oe, s_clr;
  logic [15:0] s_drv;
  logic        s_en;
  wire  [15:0] s_bus;
  logic        s_ready, s_ecf, s_ebusy;
  logic [3:0]  s_wrc, s_rdc;

  assign bus   = drv_en ? drv : 'z;
  assign s_bus = s_en ? s_drv : 'z;

  always #5 clk = ~clk;

  sram_responder dut (
    .sram_clk(clk), .rst_n(rst_n), .sram_addr_i(addr), .sram_data_io(bus),
    .sram_ce_i(ce), .sram_we_i(we), .sram_oe_i(oe), .clear_stats_i(clr),
    .ready_o(ready), .err_conflict_o(ecf), .err_busy_o(ebusy),
    .wr_count_o(wrc), .rd_count_o(rdc)
  );

  sram_responder #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .INIT_VALUE(16'h5A5A), .CNT_WIDTH(4)) dut_s (
    .sram_clk(clk), .rst_n(rst_n), .sram_addr_i(s_addr), .sram_data_io(s_bus),
    .sram_ce_i(s_ce), .sram_we_i(s_we), .sram_oe_i(s_oe), .clear_stats_i(s_clr),
    .ready_o(s_ready), .err_conflict_o(s_ecf), .err_busy_o(s_ebusy),
    .wr_count_o(s_wrc), .rd_count_o(s_rdc)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: memory contents plus statistics.
  logic [15:0] model_mem [256];
  int          m_wr, m_rd;
  logic        m_cf, m_busy;

  typedef struct {
    logic        is_wr;
    logic [7:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Undriven bus reads as Z in 4-state simulators and as 0 in 2-state ones.
  task automatic chk_z(input string nm);
    checks++;
    if (!((bus === 16'hzzzz) || (bus === 16'h0000))) begin
      failures++;
      $display("FAIL %s actual=%h required=released", nm, bus);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce = 1'b0; we = 1'b0; oe = 1'b0; drv_en = 1'b0;
  endtask

  task automatic chk_stats(input string nm);
    chk({nm, "_wrc"},  wrc,   32'(m_wr));
    chk({nm, "_rdc"},  rdc,   32'(m_rd));
    chk({nm, "_cf"},   ecf,   32'(m_cf));
    chk({nm, "_busy"}, ebusy, 32'(m_busy));
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    ce = 1'b1; we = 1'b1; oe = 1'b0; addr = a; drv = d; drv_en = 1'b1;
    tick();
    idle();
    model_mem[a] = d;
    if (m_wr < 65535) m_wr++;
  endtask

  task automatic do_conflict(input logic [7:0] a, input logic [15:0] d);
    ce = 1'b1; we = 1'b1; oe = 1'b1; addr = a; drv = d; drv_en = 1'b1;
    tick();
    idle();
    m_cf = 1'b1;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_wr = 0; m_rd = 0; m_cf = 1'b0; m_busy = 1'b0;
  endtask

  // Continuous read of n addresses: n+1 rd cycles, data for a[k] is on the
  // bus in cycle k+1, then one released cycle.
  task automatic read_burst(input logic [7:0] a[$], input logic [15:0] e[$], input string nm);
    int n;
    n = a.size();
    for (int k = 0; k <= n; k++) begin
      ce = 1'b1; oe = 1'b1; we = 1'b0; drv_en = 1'b0;
      addr = (k < n) ? a[k] : a[n-1];
      #1;
      if (k == 0) chk_z({nm, "_setup_z"});
      else        chk({nm, "_data"}, 32'(bus), 32'(e[k-1]));
      tick();
    end
    idle();
    #1;
    chk_z({nm, "_after_z"});
    tick();
    if (m_rd < 65535) m_rd++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  qa[$];
    logic [15:0] qe[$];
    int n;

    rst_n = 1'b0; clr = 1'b0; addr = '0; drv = '0; idle();
    s_addr = '0; s_ce = 1'b0; s_we = 1'b0; s_oe = 1'b0; s_clr = 1'b0; s_drv = '0; s_en = 1'b0;
    m_wr = 0; m_rd = 0; m_cf = 1'b0; m_busy = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;

    // Reset state
    #12;
    chk("rst_ready", ready, 0);
    chk_stats("rst");
    chk_z("rst_bus_z");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset mid-INIT at init_addr=0x80
    repeat (128) tick();
    chk("mid_init_ready", ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 0);
    chk_z("mid_rst_bus_z");
    tick();
    rst_n = 1'b1;

    // Full INIT must take 256 cycles; a write to 0x05 at cycle 200 is dropped.
    n = 0;
    while (!ready && n < 1000) begin
      if (n == 200) begin
        ce = 1'b1; we = 1'b1; oe = 1'b0; addr = 8'h05; drv = 16'h1234; drv_en = 1'b1;
      end else idle();
      tick();
      n++;
    end
    idle();
    m_busy = 1'b1;
    chk("init_cycles", 32'(n), 256);
    chk_stats("post_init");

    // All locations read back as INIT_VALUE
    for (int i = 0; i < 256; i++) begin
      qa = {8'(i)};
      qe = {16'h0000};
      read_burst(qa, qe, "init_rd");
    end
    chk("init_rd_count", rdc, 256);
    chk_stats("after_readback");

    do_clear();
    chk_stats("clear1");

    // Single write then setup+capture read
    do_write(8'h3C, 16'hBEEF);
    qa = {8'h3C}; qe = {16'hBEEF};
    read_burst(qa, qe, "beef");
    chk("beef_wrc", wrc, 1);
    chk("beef_rdc", rdc, 1);

    // Back-to-back writes, then a pipelined 3-address read
    do_write(8'h01, 16'h1111);
    do_write(8'h02, 16'h2222);
    qa = {8'h01, 8'h02, 8'h03}; qe = {16'h1111, 16'h2222, 16'h0000};
    read_burst(qa, qe, "pipe");
    chk("pipe_rdc", rdc, 2);
    chk("pipe_wrc", wrc, 3);

    // Vector table
    vt[0] = '{1'b1, 8'h00, 16'h0001, 16'h0000};
    vt[1] = '{1'b1, 8'hFF, 16'hFFFF, 16'h0000};
    vt[2] = '{1'b1, 8'h80, 16'h8000, 16'h0000};
    vt[3] = '{1'b1, 8'h7F, 16'h7FFF, 16'h0000};
    vt[4] = '{1'b0, 8'h00, 16'h0000, 16'h0001};
    vt[5] = '{1'b0, 8'hFF, 16'h0000, 16'hFFFF};
    vt[6] = '{1'b0, 8'h80, 16'h0000, 16'h8000};
    vt[7] = '{1'b0, 8'h7F, 16'h0000, 16'h7FFF};
    vt[8] = '{1'b0, 8'h81, 16'h0000, 16'h0000};
    vt[9] = '{1'b0, 8'h3C, 16'h0000, 16'hBEEF};
    for (int i = 0; i < 10; i++) begin
      if (vt[i].is_wr) do_write(vt[i].a, vt[i].d);
      else begin
        qa = {vt[i].a}; qe = {vt[i].exp};
        read_burst(qa, qe, $sformatf("vec%0d", i));
      end
    end
    chk_stats("vec");

    // Conflict: flag set, no write, then clear
    do_conflict(8'h10, 16'hAAAA);
    chk("cf_flag", ecf, 1);
    qa = {8'h10}; qe = {16'h0000};
    read_burst(qa, qe, "cf_rd");
    chk_stats("cf");
    do_clear();
    chk("cf_clr_flag", ecf, 0);
    chk("cf_clr_wrc", wrc, 0);
    chk("cf_clr_rdc", rdc, 0);

    // Randomized traffic against the model
    for (int it = 0; it < 300; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) do_write(8'($urandom), 16'($urandom));
      else if (op <= 6) begin
        int len;
        len = $urandom_range(1, 4);
        qa = {}; qe = {};
        for (int k = 0; k < len; k++) begin
          logic [7:0] ra;
          ra = 8'($urandom);
          qa.push_back(ra);
          qe.push_back(model_mem[ra]);
        end
        read_burst(qa, qe, "rnd_rd");
      end
      else if (op == 7) do_conflict(8'($urandom), 16'($urandom));
      else if (op == 8) do_clear();
      else tick();
      chk_stats("rnd");
    end

    // Saturation on the 4-bit counter instance
    chk("s_ready", s_ready, 1);
    for (int i = 0; i < 19; i++) begin
      s_ce = 1'b1; s_we = 1'b1; s_addr = 4'(i); s_drv = 16'(i); s_en = 1'b1;
      tick();
      if (i == 15) chk("s_wrc_16", s_wrc, 4'hF);
    end
    s_ce = 1'b0; s_we = 1'b0; s_en = 1'b0;
    tick();
    chk("s_wrc_sat", s_wrc, 4'hF);
    chk("s_rdc", s_rdc, 0);
    chk("s_busy", s_ebusy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
Synchronous SRAM target model for the sram_clk domain. It is the device end of the ce/we/oe SRAM bus that the controller drives. It holds a 2^ADDR_WIDTH x DATA_WIDTH array, writes on write strobes, and returns registered read data on the shared bidirectional bus one cycle after a read begins. It also provides post-reset array initialisation, sticky protocol-error flags and saturating access counters, for use in simulation, FPGA self-test and bus bring-up.

Parameters:
ADDR_WIDTH, 8, address width; array depth = 2^ADDR_WIDTH.
DATA_WIDTH, 16, data bus width.
INIT_VALUE, 0, word written to every location during initialisation.
CNT_WIDTH, 16, width of each access counter.

Ports:
sram_clk  in  1  clock; all logic on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
sram_addr_i  in  ADDR_WIDTH  address from controller.
sram_data_io  inout  DATA_WIDTH  shared data bus; driven only during a valid read.
sram_ce_i  in  1  chip enable, active-high.
sram_we_i  in  1  write enable, active-high.
sram_oe_i  in  1  output enable, active-high.
clear_stats_i  in  1  synchronous clear of counters and error flags.
ready_o  out  1  high once initialisation is complete.
err_conflict_o  out  1  sticky: ce&we&oe seen.
err_busy_o  out  1  sticky: ce asserted while not ready.
wr_count_o  out  CNT_WIDTH  saturating count of write cycles.
rd_count_o  out  CNT_WIDTH  saturating count of read transactions.

Behaviour:
- Reset values: state=INIT, init_addr=0, ready_o=0, both err flags=0, both counters=0, rd_q=0, bus high-Z. The array itself is not reset; INIT overwrites it.
- Decoded strobes:
  - wr = ce&we&~oe
  - rd = ce&oe&~we
  - cf = ce&we&oe
- State machine with three states: INIT, IDLE, READ.
- INIT:
  - Each cycle, mem[init_addr] <= INIT_VALUE and init_addr increments.
  - After writing the last address (all ones), go to IDLE and set ready_o the next cycle. Initialisation takes exactly 2^ADDR_WIDTH cycles.
  - Bus strobes are ignored. Any ce=1 sets err_busy_o.
- IDLE:
  - wr: mem[addr] <= data_io at the edge; stay in IDLE.
  - rd: rd_q <= mem[addr]; go to READ.
  - cf: no write and no latch; set err_conflict_o; stay in IDLE.
- READ:
  - Drive sram_data_io = rd_q combinationally while rd is high. Release to Z the same cycle rd drops.
  - rd still high: rd_q <= mem[current addr]; stay in READ. This is a pipelined read: data for address A is valid in the cycle after A is first presented.
  - wr: perform the write; go to IDLE.
  - cf: set err_conflict_o; go to IDLE.
  - Otherwise go to IDLE.
- Required controller timing:
  - Write: a single cycle with ce=we=1; data is sampled at the closing edge.
  - Read: a setup cycle latches rd_q, then a capture cycle drives rd_q. The controller samples at the end of the capture cycle.
- Read-during-write: the same-edge write and read cannot occur (the strobes are mutually exclusive). A read of an address in the cycle after a write returns the new data.
- Counters:
  - wr_count increments on each wr cycle in IDLE or READ.
  - rd_count increments on the IDLE->READ transition only, i.e. once per transaction.
  - Both saturate at all-ones, with no wrap.
- clear_stats_i:
  - Zeroes counters and error flags at the edge, and overrides a same-cycle increment or set.
  - It does not affect the array, state or ready_o.
- The bus is never driven in INIT or IDLE, or while we=1.
- Reset mid-operation: returns to INIT asynchronously, releases the bus immediately, and restarts initialisation from address 0.

Decomposition:
- Shared package sram_pkg holds:
  - state encoding constants: INIT, IDLE, READ;
  - the strobe-decode helper width constants;
  - INIT_VALUE default.
- Sub-module sram_sat_counter: parameter CNT_WIDTH, inputs inc/clr, saturating output. Instantiated twice.
- The array and FSM stay in the top module.

Test Plan:
- Reset release, ADDR_WIDTH=8 -> ready_o rises after 256 cycles; all 256 locations read back as 0x0000; rd_count=256.
- Write 0xBEEF to 0x3C (one ce&we cycle), then setup+capture read of 0x3C -> bus = 0xBEEF in the capture cycle; Z before and after; wr_count=1, rd_count=1.
- Back-to-back writes 0x01=0x1111 and 0x02=0x2222, then a continuous 3-cycle rd on addresses 0x01, 0x02, 0x03 -> bus shows 0x1111, 0x2222, 0x0000 on cycles 2-4; rd_count increments by 1.
- ce=we=oe=1 at 0x10 with data 0xAAAA -> err_conflict_o=1, mem[0x10] unchanged, bus never driven; then clear_stats_i pulse -> flag=0, counters=0.
- ce=1 write during INIT -> err_busy_o=1 and the write is dropped; assert rst_n=0 mid-INIT at init_addr=0x80 -> ready_o=0, bus Z, full 256-cycle INIT repeats.
- Force wr_count to all-ones with CNT_WIDTH=4 (16 writes, then 3 more) -> wr_count_o holds 0xF.
